// File: rtl/arbiter_pkg.sv
// Shared types and constants for the arbiter_rr block.
package arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Wide enough for any MAX_HOLD up to 255.
  localparam int unsigned HOLD_W = 8;

  // Next index after idx, wrapping modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: highest index in fixed mode, first set bit
// at or after start (wrapping) in round-robin mode.
module arb_pick
  import arbiter_pkg::*;
#(
  parameter int unsigned N   = 3,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  input  logic           mode,
  output logic [N-1:0]   win_c,
  output logic [IDW-1:0] idx_c,
  output logic           found_c
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    pos;
  int unsigned    sum;

  always_comb begin
    dbl     = {req, req};
    rot     = N'(dbl >> start);
    pos     = 0;
    sum     = 0;
    idx_c   = '0;
    found_c = |req;
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req[i]) pos = 32'(i);
      end
      idx_c = IDW'(pos);
    end else begin
      // Rotated so bit 0 is the start index; lowest set bit wins.
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (rot[i]) pos = 32'(i);
      end
      sum = 32'(start) + pos;
      if (sum >= N) sum = sum - N;
      idx_c = IDW'(sum);
    end
    win_c = found_c ? (N'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-way arbiter with fixed-priority / round-robin selection and hold-limit
// preemption; all grant outputs are registered.
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [IDW-1:0]    LAST_RST  = IDW'(N - 1);

  state_e            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDW-1:0]    last_q, last_d;

  logic [N-1:0]   pick_req;
  logic [IDW-1:0] pick_start;
  logic [N-1:0]   pick_win;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           holder_req;
  logic           others_req;
  logic           preempt;

  // The holder never competes against itself; in IDLE gnt_q is zero.
  assign pick_req   = req & ~gnt_q;
  assign pick_start = IDW'(wrap_inc(32'(last_q), N));
  assign holder_req = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  assign preempt    = (MAX_HOLD > 0) && (hold_q == HOLD_LAST) && others_req;

  arb_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req     (pick_req),
    .start   (pick_start),
    .mode    (mode),
    .win_c   (pick_win),
    .idx_c   (pick_idx),
    .found_c (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    hold_d      = hold_q;
    last_d      = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          gnt_d       = pick_win;
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
          last_d      = pick_idx;
        end
      end
      ST_GRANT: begin
        if (!holder_req || preempt) begin
          if (pick_found) begin
            gnt_d       = pick_win;
            gnt_id_d    = pick_idx;
            gnt_valid_d = 1'b1;
            hold_d      = '0;
            last_d      = pick_idx;
          end else begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            hold_d      = '0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = HOLD_W'(hold_q + 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      hold_q      <= '0;
      last_q      <= LAST_RST;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Scoreboard bench for arbiter_rr: three instances (MAX_HOLD 4, 1, 0) share
// the stimulus and are compared against a holder/held-cycles reference model.
module tb_arbiter_rr;

  localparam int MHS [3] = '{4, 1, 0};

  typedef struct packed {
    logic [2:0][2:0] gnt;
    logic [2:0][1:0] id;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       mode;
  logic [2:0] gnt0, gnt1, gnt2;
  logic [1:0] id0, id1, id2;
  logic       v0, v1, v2;

  logic [2:0] gnt_w [3];
  logic [1:0] id_w  [3];
  logic       v_w   [3];

  assign gnt_w[0] = gnt0;
  assign gnt_w[1] = gnt1;
  assign gnt_w[2] = gnt2;
  assign id_w[0]  = id0;
  assign id_w[1]  = id1;
  assign id_w[2]  = id2;
  assign v_w[0]   = v0;
  assign v_w[1]   = v1;
  assign v_w[2]   = v2;

  arbiter_rr #(.N(3), .MAX_HOLD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0));
  arbiter_rr #(.N(3), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt1), .gnt_id(id1), .gnt_valid(v1));
  arbiter_rr #(.N(3), .MAX_HOLD(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt2), .gnt_id(id2), .gnt_valid(v2));

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q [$];

  // Reference model: current holder (-1 = none), cycles held, last holder.
  int m_holder [3];
  int m_held   [3];
  int m_last   [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit bit_of(input logic [2:0] v, input int i);
    return ((v >> i) & 3'd1) != 3'd0;
  endfunction

  function automatic logic [2:0] onehot(input int i);
    return 3'd1 << i;
  endfunction

  function automatic int pick_ref(input logic [2:0] r, input logic md, input int last);
    if (md == 1'b0) begin
      for (int i = 2; i >= 0; i--) if (bit_of(r, i)) return i;
    end else begin
      for (int k = 1; k <= 3; k++) if (bit_of(r, (last + k) % 3)) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_holder[k] = -1;
      m_held[k]   = 0;
      m_last[k]   = 2;
    end
  endtask

  task automatic model_step(input int k, input logic [2:0] r, input logic md);
    int         h;
    bit         choose;
    logic [2:0] cand;
    int         w;
    h      = m_holder[k];
    choose = 1'b0;
    cand   = r;
    if (h < 0) begin
      choose = (r != 3'd0);
    end else if (!bit_of(r, h)) begin
      if (r != 3'd0) choose = 1'b1;
      else begin
        m_holder[k] = -1;
        m_held[k]   = 0;
      end
    end else if (MHS[k] > 0 && m_held[k] >= MHS[k] && (r & ~onehot(h)) != 3'd0) begin
      choose = 1'b1;
      cand   = r & ~onehot(h);
    end else begin
      m_held[k]++;
    end
    if (choose) begin
      w           = pick_ref(cand, md, m_last[k]);
      m_holder[k] = w;
      m_held[k]   = 1;
      m_last[k]   = w;
    end
  endtask

  // Apply one cycle of stimulus and queue the expected post-edge outputs.
  task automatic step(input logic [2:0] r, input logic md);
    exp_t e;
    @(negedge clk);
    req  = r;
    mode = md;
    for (int k = 0; k < 3; k++) begin
      model_step(k, r, md);
      e.gnt[k] = (m_holder[k] < 0) ? 3'd0 : onehot(m_holder[k]);
      e.id[k]  = (m_holder[k] < 0) ? 2'd0 : 2'(m_holder[k]);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Directed expectation on instance 0 (MAX_HOLD = 4); id < 0 means no grant.
  task automatic expect0(input string name, input int id);
    if (id < 0) check(name, int'({v0, id0, gnt0}), 0);
    else check(name, int'({v0, id0, gnt0}), int'({1'b1, 2'(id), onehot(id)}));
  endtask

  // Monitor: pops one expectation per edge at which one was queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          check($sformatf("sb_gnt%0d", k), int'(gnt_w[k]), int'(e.gnt[k]));
          check($sformatf("sb_id%0d", k), int'(id_w[k]), int'(e.id[k]));
          check($sformatf("sb_valid%0d", k), int'(v_w[k]), int'(e.gnt[k] != 3'd0));
        end
      end
    end
  end

  initial begin
    int         waitc [2][3];
    int         worst;
    logic [2:0] r;

    rst_n = 1'b0;
    req   = 3'd0;
    mode  = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", int'({v0, id0, gnt0, v1, id1, gnt1, v2, id2, gnt2}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin rotation with all requesters asserting.
    for (int c = 0; c < 16; c++) begin
      step(3'b111, 1'b1);
      expect0("rr_rotate", (c / 4) % 3);
    end
    step(3'b000, 1'b1);
    expect0("rr_release", -1);

    // Fixed mode: 1 holds MAX_HOLD cycles then yields to 2.
    step(3'b011, 1'b0);
    expect0("fixed_first", 1);
    for (int c = 0; c < 3; c++) begin
      step(3'b111, 1'b0);
      expect0("fixed_hold", 1);
    end
    step(3'b111, 1'b0);
    expect0("fixed_preempt", 2);
    step(3'b000, 1'b0);
    expect0("fixed_release", -1);

    // Holder drops with others waiting: direct handover, then idle.
    for (int m = 1; m >= 0; m--) begin
      step(3'b010, 1'(m));
      expect0("drop_first", 1);
      step(3'b101, 1'(m));
      expect0("drop_handover", 2);
      step(3'b000, 1'(m));
      expect0("drop_idle", -1);
    end

    // Lone requester keeps the grant indefinitely.
    for (int c = 0; c < 10; c++) begin
      step(3'b010, 1'b1);
      expect0("lone_hold", 1);
    end

    // Asynchronous reset mid-grant, then restart from requester 0.
    step(3'b111, 1'b1);
    expect0("pre_reset_grant", 2);
    step(3'b111, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = 3'd0;
    #1;
    check("async_reset_clear", int'({v0, id0, gnt0, v1, id1, gnt1, v2, id2, gnt2}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b111, 1'b1);
    expect0("post_reset_first", 0);

    // Random traffic: round-robin phase with starvation bound, then fixed.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) waitc[k][i] = 0;
    for (int c = 0; c < 5000; c++) begin
      r = 3'd0;
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 3) != 0) r = r | onehot(i);
      step(r, 1'b1);
      for (int k = 0; k < 2; k++) begin
        worst = 0;
        for (int i = 0; i < 3; i++) begin
          if (bit_of(r, i) && !bit_of(gnt_w[k], i)) waitc[k][i]++;
          else waitc[k][i] = 0;
          if (waitc[k][i] > worst) worst = waitc[k][i];
        end
        n_checks++;
        if (worst > 2 * MHS[k] + 1) begin
          n_fail++;
          $display("FAIL starvation inst%0d at %0t: waited %0d, limit %0d",
                   k, $time, worst, 2 * MHS[k] + 1);
        end
      end
    end
    for (int c = 0; c < 5000; c++) begin
      step(3'($urandom_range(0, 7)), 1'b0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 Parameter N, default 3: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles while others wait; 0 disables preemption; legal range 0..255.
REQ-003 Parameter IDW, default $clog2(N): width of the grant index.
REQ-004 Clock and reset: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  N  request vector; bit i is requester i; level-sensitive.
REQ-008 mode  input  1  0 = fixed priority (index N-1 highest); 1 = round-robin.
REQ-009 gnt  output  N  registered one-hot grant, or all zero.
REQ-010 gnt_id  output  IDW  registered index of the granted requester; 0 when gnt_valid = 0.
REQ-011 gnt_valid  output  1  registered; 1 when exactly one gnt bit is set.

Function
REQ-012 Outputs are Moore outputs: gnt, gnt_id and gnt_valid SHALL be driven only from registers, never combinationally from req.
REQ-013 The state machine SHALL have two states. IDLE: no grant. GRANT: one holder.
REQ-014 IDLE -> GRANT SHALL occur at the first rising edge at which req != 0; the winner is visible one cycle after req is first sampled.
REQ-015 GRANT -> GRANT with the same holder SHALL occur while req[holder] = 1 and no preemption applies (REQ-018).
REQ-016 When req[holder] = 0 is sampled and another req bit is set, the grant SHALL move to the new winner at that same edge, with no idle bubble.
REQ-017 When req[holder] = 0 is sampled and req = 0, the FSM SHALL go to IDLE with gnt = 0.
REQ-018 Preemption (MAX_HOLD > 0): a hold counter SHALL count grant cycles of the current holder; when it equals MAX_HOLD - 1 and another requester is asserting req, the next edge SHALL grant the winner among the other requesters, excluding the holder.
REQ-019 If no other requester is asserting req, preemption SHALL NOT occur; the holder SHALL keep the grant and the counter SHALL saturate at MAX_HOLD - 1.
REQ-020 The hold counter SHALL reset to 0 on every change of holder and in IDLE.
REQ-021 Fixed mode: the winner SHALL be the highest asserted index.
REQ-022 Round-robin mode: the search SHALL start at index last+1, wrap modulo N, and take the first asserted index; last is the index of the most recent holder.
REQ-023 The last pointer SHALL update only when a grant is issued, and SHALL persist through IDLE.
REQ-024 A mode change SHALL NOT affect the current holder; the new mode SHALL apply at the next winner selection.
REQ-025 At most one gnt bit SHALL be set in any cycle.
REQ-026 gnt_id SHALL equal the index of the set gnt bit.

Reset
REQ-027 While rst_n = 0: state = IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, hold counter = 0, last = N-1, so the first round-robin grant searches from index 0.
REQ-028 A reset asserted mid-grant SHALL clear the grant immediately (asynchronously).
REQ-029 After rst_n deasserts, arbitration SHALL resume at the first rising edge with req != 0.

Structure
REQ-030 The shared package arbiter_pkg SHALL hold the FSM state enum (ST_IDLE, ST_GRANT) and the mode constants MODE_FIXED = 0 and MODE_RR = 1.
REQ-031 Winner selection SHALL be a combinational sub-module arb_pick with inputs req (masked), start index and mode, and outputs one-hot winner, index and found; arbiter_rr instantiates it once.

Verification
REQ-032 Defaults (N=3, MAX_HOLD=4). mode=1, reset released, req=3'b111 held. Required: grants to requesters 0,1,2,0 in turn, each held 4 cycles, with gnt_valid continuously 1.
REQ-033 mode=0, req=3'b011, then req[2] raised while 1 is holding. Required: 1 keeps the grant for 4 cycles, then the grant moves to 2 (3'b100, gnt_id=2).
REQ-034 Holder 1 drops req while req=3'b101. Required: at the next edge gnt moves to 2 in RR mode, or to 2 in fixed mode, with no zero-grant cycle; then req=0 -> gnt=0 and gnt_valid=0 one edge later.
REQ-035 req=3'b010 held for 10 cycles with no others. Required: gnt=3'b010 throughout, no preemption, counter saturated at 3.
REQ-036 rst_n pulsed low during a grant. Required: gnt=0 immediately; after release with req=3'b111 in RR mode, the first grant goes to requester 0.
REQ-037 Random req over 10k cycles, both modes, MAX_HOLD in {0,1,4}. Required: one-hot-or-zero gnt, gnt_id consistent with gnt, and no requester starved beyond (N-1)*MAX_HOLD+1 cycles in RR mode with MAX_HOLD>0.
